// File: rtl/watch_time_gen_if.sv
// Bus bundle for watch_time_gen: control, load/alarm inputs and time outputs.
// master drives the controls, slave is the time keeper.
interface watch_time_gen_if #(
  parameter int HW    = 5,
  parameter int MW    = 6,
  parameter int N_ALM = 2,
  parameter int AW    = 1
);
  logic                en_1hz;
  logic                run;
  logic                ampm_sw;
  logic                set_watch;
  logic [HW+2*MW-1:0]  bin_watch;
  logic                alm_wr;
  logic [AW-1:0]       alm_idx;
  logic [HW+2*MW-1:0]  alm_data;
  logic [N_ALM-1:0]    alm_en;
  logic [HW-1:0]       hour;
  logic [HW-1:0]       hour_ampm;
  logic                ampm;
  logic [MW-1:0]       min;
  logic [MW-1:0]       sec;
  logic                en_day;
  logic [N_ALM-1:0]    alm_hit;
  logic                set_err;

  modport master (
    output en_1hz, run, ampm_sw, set_watch, bin_watch,
    output alm_wr, alm_idx, alm_data, alm_en,
    input  hour, hour_ampm, ampm, min, sec,
    input  en_day, alm_hit, set_err
  );

  modport slave (
    input  en_1hz, run, ampm_sw, set_watch, bin_watch,
    input  alm_wr, alm_idx, alm_data, alm_en,
    output hour, hour_ampm, ampm, min, sec,
    output en_day, alm_hit, set_err
  );
endinterface

// File: rtl/watch_time_gen.sv
// Time-of-day keeper: h:m:s carry chain, range-checked loads,
// 12-hour view and per-channel alarm compare on tick arrivals.
module watch_time_gen #(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59,
  parameter int SEC_MAX  = 59,
  parameter int HW       = 5,
  parameter int MW       = 6,
  parameter int N_ALM    = 2,
  parameter int AW       = 1
) (
  input logic             clk,
  input logic             rst,
  watch_time_gen_if.slave bus
);
  localparam int TW = HW + 2*MW;
  localparam logic [HW-1:0] H_MAX = HW'(HOUR_MAX);
  localparam logic [MW-1:0] M_MAX = MW'(MIN_MAX);
  localparam logic [MW-1:0] S_MAX = MW'(SEC_MAX);
  localparam logic [AW:0]   N_CH  = (AW+1)'(N_ALM);
  localparam bit            IS_24H = (HOUR_MAX == 23);

  logic [HW-1:0]    hour_q, hour_d;
  logic [MW-1:0]    min_q, min_d;
  logic [MW-1:0]    sec_q, sec_d;
  logic [TW-1:0]    alm_q [N_ALM];
  logic             set_ok, wr_ok, tick, day_wrap;
  logic [N_ALM-1:0] hit_d;
  logic             en_day_q, set_err_q;
  logic [N_ALM-1:0] alm_hit_q;

  function automatic logic fields_ok(input logic [TW-1:0] v);
    return (v[TW-1 -: HW] <= H_MAX) &&
           (v[2*MW-1 -: MW] <= M_MAX) &&
           (v[MW-1:0] <= S_MAX);
  endfunction

  always_comb begin
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    day_wrap = 1'b0;
    hit_d    = '0;
    set_ok   = fields_ok(bus.bin_watch);
    wr_ok    = fields_ok(bus.alm_data) &&
               ({1'b0, bus.alm_idx} < N_CH);
    tick     = bus.en_1hz && bus.run && !bus.set_watch;
    unique case (1'b1)
      bus.set_watch: begin
        if (set_ok) {hour_d, min_d, sec_d} = bus.bin_watch;
      end
      tick: begin
        if (sec_q != S_MAX) begin
          sec_d = sec_q + 1'b1;
        end else begin
          sec_d = '0;
          if (min_q != M_MAX) begin
            min_d = min_q + 1'b1;
          end else begin
            min_d = '0;
            if (hour_q != H_MAX) begin
              hour_d = hour_q + 1'b1;
            end else begin
              hour_d   = '0;
              day_wrap = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    // Only tick arrivals fire, so loads and alarm rewrites stay silent
    for (int i = 0; i < N_ALM; i++)
      hit_d[i] = tick && bus.alm_en[i] &&
                 ({hour_d, min_d, sec_d} == alm_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      en_day_q  <= 1'b0;
      set_err_q <= 1'b0;
      alm_hit_q <= '0;
      for (int i = 0; i < N_ALM; i++)
        alm_q[i] <= '0;
    end else begin
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      en_day_q  <= day_wrap;
      alm_hit_q <= hit_d;
      set_err_q <= (bus.set_watch && !set_ok) ||
                   (bus.alm_wr && !wr_ok);
      for (int i = 0; i < N_ALM; i++)
        if (bus.alm_wr && wr_ok && bus.alm_idx == AW'(i))
          alm_q[i] <= bus.alm_data;
    end
  end

  always_comb begin
    bus.hour_ampm = hour_q;
    bus.ampm      = 1'b0;
    if (IS_24H) begin
      bus.ampm = (hour_q >= HW'(12));
      if (bus.ampm_sw) begin
        if (hour_q == '0)
          bus.hour_ampm = HW'(12);
        else if (hour_q > HW'(12))
          bus.hour_ampm = hour_q - HW'(12);
      end
    end
  end

  assign bus.hour    = hour_q;
  assign bus.min     = min_q;
  assign bus.sec     = sec_q;
  assign bus.en_day  = en_day_q;
  assign bus.alm_hit = alm_hit_q;
  assign bus.set_err = set_err_q;
endmodule

// File: tb/tb_watch_time_gen.sv
// Bench for watch_time_gen: seconds-of-day reference model with random
// and directed stimulus, plus a reduced-range instance.
module tb_watch_time_gen;
  localparam int DAY = 86400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  int m_t;
  int m_alm [2];

  watch_time_gen_if #(.HW(5), .MW(6), .N_ALM(2), .AW(1)) b ();
  watch_time_gen_if #(.HW(4), .MW(3), .N_ALM(3), .AW(2)) sb ();

  watch_time_gen u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  watch_time_gen #(
    .HOUR_MAX(9), .MIN_MAX(5), .SEC_MAX(5),
    .HW(4), .MW(3), .N_ALM(3), .AW(2)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] pack(input int t);
    return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  function automatic bit decode(input logic [16:0] v, output int t);
    int h, m, s;
    h = int'(v[16:12]);
    m = int'(v[11:6]);
    s = int'(v[5:0]);
    t = h * 3600 + m * 60 + s;
    return (h < 24) && (m < 60) && (s < 60);
  endfunction

  task automatic idle();
    b.en_1hz = 0; b.set_watch = 0; b.alm_wr = 0;
    b.run = 1; b.bin_watch = '0; b.alm_data = '0; b.alm_idx = '0;
  endtask

  // Model one clock, advance, then compare every output
  task automatic step();
    int t, h;
    bit err, day;
    logic [1:0] hit;
    err = 0; day = 0; hit = '0;
    if (b.set_watch) begin
      if (decode(b.bin_watch, t)) m_t = t;
      else err = 1;
    end else if (b.en_1hz && b.run) begin
      m_t = (m_t + 1) % DAY;
      day = (m_t == 0);
      for (int i = 0; i < 2; i++)
        hit[i] = b.alm_en[i] && (m_alm[i] == m_t);
    end
    if (b.alm_wr) begin
      if (decode(b.alm_data, t)) m_alm[int'(b.alm_idx)] = t;
      else err = 1;
    end
    @(posedge clk);
    #1;
    h = m_t / 3600;
    chk("hour", 32'(b.hour), 32'(h));
    chk("min", 32'(b.min), 32'((m_t / 60) % 60));
    chk("sec", 32'(b.sec), 32'(m_t % 60));
    chk("hour_ampm", 32'(b.hour_ampm),
        b.ampm_sw ? 32'(((h + 11) % 12) + 1) : 32'(h));
    chk("ampm", 32'(b.ampm), 32'(h >= 12));
    chk("en_day", 32'(b.en_day), 32'(day));
    chk("alm_hit", 32'(b.alm_hit), 32'(hit));
    chk("set_err", 32'(b.set_err), 32'(err));
  endtask

  task automatic load(input int t);
    b.set_watch = 1; b.bin_watch = pack(t);
    step();
    b.set_watch = 0;
  endtask

  task automatic tick1();
    b.en_1hz = 1;
    step();
    b.en_1hz = 0;
  endtask

  task automatic sstep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    idle();
    b.ampm_sw = 1; b.alm_en = '0;
    sb.en_1hz = 0; sb.run = 1; sb.ampm_sw = 1; sb.set_watch = 0;
    sb.bin_watch = '0; sb.alm_wr = 0; sb.alm_idx = '0;
    sb.alm_data = '0; sb.alm_en = '0;
    m_t = 0; m_alm[0] = 0; m_alm[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_hour", 32'(b.hour), 0);
    chk("rst_hour_ampm", 32'(b.hour_ampm), 12);
    chk("rst_ampm", 32'(b.ampm), 0);
    chk("rst_pulses", 32'({b.en_day, b.alm_hit, b.set_err}), 0);

    // midnight wrap
    load(23 * 3600 + 59 * 60 + 58);
    tick1();
    tick1();
    step();
    // rejected loads, 12-hour view
    load(13 * 3600 + 5 * 60);
    b.set_watch = 1; b.bin_watch = {5'd24, 6'd0, 6'd0}; step();
    b.bin_watch = {5'd1, 6'd60, 6'd0}; step();
    b.set_watch = 0;
    step();
    b.ampm_sw = 0; step();
    b.ampm_sw = 1;
    // load wins over a coincident tick, hold when stopped
    b.en_1hz = 1; load(10 * 3600);
    b.en_1hz = 0;
    b.run = 0;
    repeat (5) tick1();
    b.run = 1;
    // alarms
    b.alm_wr = 1; b.alm_idx = 0; b.alm_data = pack(7 * 3600 + 30 * 60); step();
    b.alm_idx = 1; step();
    b.alm_wr = 0; b.alm_en = 2'b01;
    load(7 * 3600 + 29 * 60 + 59);
    tick1();
    step();
    load(7 * 3600 + 30 * 60);
    b.alm_wr = 1; b.alm_idx = 0; b.alm_data = {5'd8, 6'd61, 6'd0}; step();
    b.alm_wr = 0; b.alm_en = 2'b11;
    load(7 * 3600 + 29 * 59 + 59);
    load(7 * 3600 + 29 * 60 + 59);
    tick1();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      b.en_1hz    = 1'($urandom_range(0, 1));
      b.run       = ($urandom_range(0, 7) != 0);
      b.ampm_sw   = 1'($urandom_range(0, 1));
      b.set_watch = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 3);
      b.bin_watch = (r == 0) ? 17'($urandom) :
                    (r == 1) ? pack(DAY - $urandom_range(1, 3)) :
                    pack($urandom_range(0, DAY - 1));
      b.alm_wr    = ($urandom_range(0, 7) == 0);
      b.alm_idx   = 1'($urandom);
      b.alm_data  = ($urandom_range(0, 3) == 0) ? 17'($urandom) :
                    pack((m_t + $urandom_range(1, 3)) % DAY);
      b.alm_en    = 2'($urandom);
      step();
    end
    idle();

    // reduced-range instance
    sb.set_watch = 1; sb.bin_watch = {4'd9, 3'd5, 3'd5};
    sstep();
    sb.set_watch = 0;
    chk("s_load_hour", 32'(sb.hour), 9);
    chk("s_view_hour", 32'(sb.hour_ampm), 9);
    sb.en_1hz = 1;
    sstep();
    sb.en_1hz = 0;
    chk("s_wrap_time", 32'({sb.hour, sb.min, sb.sec}), 0);
    chk("s_en_day", 32'(sb.en_day), 1);
    chk("s_view_zero", 32'(sb.hour_ampm), 0);
    chk("s_ampm", 32'(sb.ampm), 0);
    sb.alm_wr = 1; sb.alm_idx = 2'd3; sb.alm_data = '0;
    sstep();
    sb.alm_wr = 0;
    chk("s_idx_err", 32'(sb.set_err), 1);
    chk("s_en_day_once", 32'(sb.en_day), 0);
    sstep();
    chk("s_err_once", 32'(sb.set_err), 0);
    sb.set_watch = 1; sb.bin_watch = {4'd3, 3'd2, 3'd1};
    sstep();
    sb.set_watch = 0; sb.en_1hz = 1;
    sstep();
    sb.en_1hz = 0;
    chk("s_count", 32'({sb.hour, sb.min, sb.sec}), 32'({4'd3, 3'd2, 3'd2}));

    // async reset kills a pending day pulse
    load(DAY - 1);
    tick1();
    rst = 1;
    #1;
    chk("mrst_en_day", 32'(b.en_day), 0);
    chk("mrst_time", 32'({b.hour, b.min, b.sec}), 0);
    chk("mrst_pulses", 32'({b.alm_hit, b.set_err}), 0);
    chk("mrst_small", 32'({sb.hour, sb.min, sb.sec, sb.en_day}), 0);
    m_t = 0; m_alm[0] = 0; m_alm[1] = 0;
    #2 rst = 0;
    b.alm_en = '0;
    step();
    tick1();
    tick1();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
